hwpe_stream_protocol_monitor: RTL

//  Synthesisable, parametrised checker for the HWPE stream and TCDM handshake rules, for use on silicon/FPGA.

---
 rtl/hwpe_stream_protocol_monitor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hwpe_stream_protocol_monitor.sv
// Passive checker for HWPE stream and TCDM handshake rules. Registers all outputs
// and keeps sticky flags, a saturating error count and the first error's identity.
module hwpe_stream_protocol_monitor #(
  parameter int NB_STREAMS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NB_TCDM    = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int MAX_CH    = (NB_STREAMS > NB_TCDM) ? NB_STREAMS : NB_TCDM,
  localparam int ID_WIDTH  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             enable_i,
  input  logic [NB_STREAMS-1:0]            stream_valid_i,
  input  logic [NB_STREAMS-1:0]            stream_ready_i,
  input  logic [NB_STREAMS*DATA_WIDTH-1:0] stream_data_i,
  input  logic [NB_STREAMS*DATA_WIDTH/8-1:0] stream_strb_i,
  input  logic [NB_TCDM-1:0]               tcdm_req_i,
  input  logic [NB_TCDM-1:0]               tcdm_gnt_i,
  input  logic [NB_TCDM-1:0]               tcdm_wen_i,
  input  logic [NB_TCDM-1:0]               tcdm_r_valid_i,
  output logic                             err_o,
  output logic [NB_STREAMS-1:0]            err_change_o,
  output logic [NB_STREAMS-1:0]            err_deassert_o,
  output logic [NB_TCDM-1:0]               err_rmiss_o,
  output logic [NB_TCDM-1:0]               err_rspur_o,
  output logic [CNT_WIDTH-1:0]             err_count_o,
  output logic                             first_valid_o,
  output logic [1:0]                       first_type_o,
  output logic [ID_WIDTH-1:0]              first_id_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int NB_VIOL    = 2 * NB_STREAMS + 2 * NB_TCDM;
  localparam int SUM_WIDTH  = CNT_WIDTH + $clog2(NB_VIOL + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [NB_STREAMS-1:0]            valid_q, ready_q;
  logic [NB_STREAMS*DATA_WIDTH-1:0] data_q;
  logic [NB_STREAMS*STRB_WIDTH-1:0] strb_q;
  logic [NB_TCDM-1:0]               rd_q;
  logic                             hist_q;

  logic [NB_STREAMS-1:0]            change_v, deassert_v;
  logic [NB_TCDM-1:0]               rmiss_v, rspur_v;
  logic                             chk_en, stalled, first_hit;
  logic [1:0]                       first_type_n;
  logic [ID_WIDTH-1:0]              first_id_n;
  logic [SUM_WIDTH-1:0]             count_sum;
  logic [CNT_WIDTH-1:0]             count_n;

  always_comb begin
    chk_en     = enable_i & hist_q;
    stalled    = 1'b0;
    change_v   = '0;
    deassert_v = '0;
    for (int c = 0; c < NB_STREAMS; c++) begin
      stalled       = chk_en & valid_q[c] & ~ready_q[c];
      change_v[c]   = stalled &
                      ((stream_data_i[c*DATA_WIDTH +: DATA_WIDTH] != data_q[c*DATA_WIDTH +: DATA_WIDTH]) |
                       (stream_strb_i[c*STRB_WIDTH +: STRB_WIDTH] != strb_q[c*STRB_WIDTH +: STRB_WIDTH]));
      deassert_v[c] = stalled & ~stream_valid_i[c];
    end
    // a write grant leaves rd_q low, so any r_valid after it is spurious
    rmiss_v = {NB_TCDM{chk_en}} & rd_q & ~tcdm_r_valid_i;
    rspur_v = {NB_TCDM{chk_en}} & ~rd_q & tcdm_r_valid_i;
  end

  // lowest type wins, then lowest index
  always_comb begin
    first_hit    = 1'b0;
    first_type_n = 2'd0;
    first_id_n   = '0;
    for (int c = 0; c < NB_STREAMS; c++)
      if (!first_hit && change_v[c]) begin
        first_hit = 1'b1; first_type_n = 2'd0; first_id_n = ID_WIDTH'(c);
      end
    for (int c = 0; c < NB_STREAMS; c++)
      if (!first_hit && deassert_v[c]) begin
        first_hit = 1'b1; first_type_n = 2'd1; first_id_n = ID_WIDTH'(c);
      end
    for (int p = 0; p < NB_TCDM; p++)
      if (!first_hit && rmiss_v[p]) begin
        first_hit = 1'b1; first_type_n = 2'd2; first_id_n = ID_WIDTH'(p);
      end
    for (int p = 0; p < NB_TCDM; p++)
      if (!first_hit && rspur_v[p]) begin
        first_hit = 1'b1; first_type_n = 2'd3; first_id_n = ID_WIDTH'(p);
      end
  end

  always_comb begin
    count_sum = SUM_WIDTH'(err_count_o) +
                SUM_WIDTH'($countones({change_v, deassert_v, rmiss_v, rspur_v}));
    count_n   = (count_sum > SUM_WIDTH'(CNT_MAX)) ? CNT_MAX : count_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      valid_q        <= '0;
      ready_q        <= '0;
      data_q         <= '0;
      strb_q         <= '0;
      rd_q           <= '0;
      hist_q         <= 1'b0;
      err_change_o   <= '0;
      err_deassert_o <= '0;
      err_rmiss_o    <= '0;
      err_rspur_o    <= '0;
      err_count_o    <= '0;
      first_valid_o  <= 1'b0;
      first_type_o   <= 2'd0;
      first_id_o     <= '0;
    end else begin
      valid_q        <= stream_valid_i;
      ready_q        <= stream_ready_i;
      data_q         <= stream_data_i;
      strb_q         <= stream_strb_i;
      rd_q           <= tcdm_req_i & tcdm_gnt_i & tcdm_wen_i;
      hist_q         <= enable_i;
      err_change_o   <= err_change_o | change_v;
      err_deassert_o <= err_deassert_o | deassert_v;
      err_rmiss_o    <= err_rmiss_o | rmiss_v;
      err_rspur_o    <= err_rspur_o | rspur_v;
      err_count_o    <= count_n;
      if (!first_valid_o && first_hit) begin
        first_valid_o <= 1'b1;
        first_type_o  <= first_type_n;
        first_id_o    <= first_id_n;
      end
    end
  end

  assign err_o = |{err_change_o, err_deassert_o, err_rmiss_o, err_rspur_o};

endmodule
